uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
//
// PURPOSE
//   Shares one UART transmit line between N_REQ byte-stream requesters.
//   Each requester offers bytes on a valid/ready handshake. Arbitration is round-robin at
//   packet granularity, so a multi-byte message such as "Hello World!\n" is never
//   interleaved with bytes from another requester.
//   Sequences a single 8N1 byte serializer and sits between message sources and the tx pin.
//
// PARAMETERS
//   N_REQ         4   number of requesters, 2..8
//   CLKS_PER_BIT  1   clk cycles per UART bit, >=1
//
// PORTS
//   clk        in   1          single clock; all state updates on posedge
//   rst        in   1          asynchronous, active-high reset
//   req_valid  in   N_REQ      requester i offers req_data[i*8+:8]
//   req_data   in   8*N_REQ    byte per requester, packed, requester 0 in LSBs
//   req_last   in   N_REQ      offered byte is the last of its packet
//   req_ready  out  N_REQ      one-hot or zero; byte accepted when valid&ready
//   tx         out  1          UART line, idle high
//   busy       out  1          high while a frame is on the line or a packet is locked
//   grant_id   out  $clog2(N)  requester currently owning the line (last owner when idle)
//
// BEHAVIOUR
//   Reset (async, immediate): tx=1, req_ready=0, busy=0, grant_id=0, rr_ptr=0, state=IDLE.
//   - Reset mid-frame aborts the frame and the in-flight byte is dropped.
//   - tx returns to 1 without waiting for a clock edge.
//   Frame format: start(0), d[0]..d[7] LSB first, stop(1); each bit lasts CLKS_PER_BIT cycles.
//   States:
//   - IDLE: winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, .. mod N_REQ.
//     req_ready[winner]=1 combinationally, from state, rr_ptr and req_valid only.
//     On acceptance: capture data and last, set grant_id=winner, pulse serializer start,
//     go to SEND.
//   - SEND: req_ready=0; wait for serializer done. Then:
//     - last=1: rr_ptr = grant_id+1 mod N_REQ, go to IDLE.
//     - last=0: go to LOCK.
//   - LOCK: only req_ready[grant_id] may assert, equal to req_valid[grant_id].
//     On acceptance, capture and go to SEND. Other requesters stall indefinitely.
//     If the owner drops valid, tx stays high and the block waits.
//   Timing:
//   - Acceptance in cycle T puts the start bit on tx from T+1.
//   - The stop bit ends at T+10*CLKS_PER_BIT.
//   - The serializer asserts done in the final stop-bit cycle.
//   - The earliest next acceptance is T+10*CLKS_PER_BIT+1, giving exactly one extra idle-high
//     cycle between back-to-back frames.
//   busy = (state!=IDLE). grant_id holds its value in IDLE.
//   Simultaneous valids in IDLE: the round-robin order decides; non-winners see ready=0.
//   A requester dropping valid without handshake is legal. Data may change while valid=0.
//   rr_ptr wraps N_REQ-1 -> 0. With N_REQ not a power of two, the wrap is an explicit compare.
//
// STRUCTURE
//   Shared package uart_pkg:
//   - UART_DATA_BITS=8, UART_START_BIT=1'b0, UART_STOP_BIT=1'b1.
//   - typedef enum logic [1:0] {SCH_IDLE, SCH_SEND, SCH_LOCK} sch_state_t.
//   - typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t.
//   Sub-module uart_tx_byte #(CLKS_PER_BIT):
//   - Ports: clk, rst, start, data[7:0], tx, done.
//   - Owns the bit counter and baud counter.
//   - Ignores start unless TX_IDLE.
//   The scheduler holds the arbiter, the lock FSM and the capture register.
//
// TESTING
//   1. Single byte: rst, then req_valid[2]=1, data=8'h48, last=1, CLKS_PER_BIT=1
//      -> ready[2] in the same cycle; tx = 0,0,0,0,1,0,0,1,0,1 from T+1;
//      grant_id=2; busy low at T+11.
//   2. Contention: all four valid with last=1, distinct bytes
//      -> grant order 0,1,2,3,0; each frame separated by exactly one idle-high cycle.
//   3. Packet lock: req1 sends "Hi\n" (last on '\n') while req0 is valid throughout
//      -> frames 'H','i','\n' all from req1; req0 is granted only after '\n';
//      req_ready[0]=0 during the lock.
//   4. Owner stall: req3 drops valid after a non-last byte for 50 cycles while req0 is valid
//      -> tx high and ready=0 for all requesters until req3 resumes; req3's byte is sent first.
//   5. Reset mid-frame: assert rst during data bit 4
//      -> tx=1 immediately, busy=0, rr_ptr=0; after release a new request gets a complete,
//      correct frame.
//   6. CLKS_PER_BIT=3, N_REQ=3: byte 8'hA5 from req2, then req0
//      -> every bit lasts 3 cycles; next acceptance at T+31; rr_ptr wraps 2->0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and state encodings for the transmit
// scheduler and its byte serializer.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        SCH_IDLE,
        SCH_SEND,
        SCH_LOCK
    } sch_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit.
// done is high in the final stop-bit cycle.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt;
    logic          w_bit_end;

    // Frame state, counters and a registered line driver; reset idles the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= UART_STOP_BIT;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Next-state logic: each bit lasts CLKS_PER_BIT cycles; start is ignored unless idle.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_bit_end   = (r_baud == BAUD_LAST);
        done        = 1'b0;
        unique case (r_state)
            TX_IDLE: begin
                w_baud_nxt = '0;
                if (start) begin
                    w_state_nxt = TX_START;
                    w_shift_nxt = data;
                    w_tx_nxt    = UART_START_BIT;
                end
            end
            TX_START: begin
                if (w_bit_end) begin
                    w_state_nxt = TX_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            TX_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = TX_STOP;
                        w_tx_nxt    = UART_STOP_BIT;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            TX_STOP: begin
                if (w_bit_end) begin
                    done        = 1'b1;
                    w_state_nxt = TX_IDLE;
                    w_baud_nxt  = '0;
                    w_tx_nxt    = UART_STOP_BIT;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
                w_tx_nxt    = UART_STOP_BIT;
            end
        endcase
    end

    assign tx = r_tx;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-granular sharing of one UART tx line between
// N_REQ byte-stream requesters.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int CLKS_PER_BIT = 1,
    localparam int IW           = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    localparam logic [IW:0]   N_WIDE   = (IW + 1)'(N_REQ);
    localparam logic [IW-1:0] ID_LAST  = IW'(N_REQ - 1);

    sch_state_t    r_state, w_state_nxt;
    logic [IW-1:0] r_rr;
    logic [IW-1:0] r_grant;
    logic          r_last;
    logic [IW-1:0] w_win;
    logic [IW-1:0] w_sel;
    logic [IW-1:0] w_grant_inc;
    logic          w_any;
    logic          w_accept;
    logic          w_done;
    logic [7:0]    w_byte;

    // Round-robin scan from r_rr; lowest offset with valid wins.
    always_comb begin
        logic [IW:0] v_idx;
        v_idx = '0;
        w_win = '0;
        w_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_idx = {1'b0, r_rr} + (IW + 1)'(k);
            if (v_idx >= N_WIDE) begin
                v_idx = v_idx - N_WIDE;
            end
            if (req_valid[v_idx[IW-1:0]]) begin
                w_win = v_idx[IW-1:0];
                w_any = 1'b1;
            end
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SCH_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready generation and next state: free arbitration in IDLE, owner-only in LOCK.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_sel       = w_win;
        unique case (r_state)
            SCH_IDLE: begin
                if (w_any) begin
                    req_ready[w_win] = 1'b1;
                    w_state_nxt      = SCH_SEND;
                end
            end
            SCH_SEND: begin
                if (w_done) begin
                    w_state_nxt = r_last ? SCH_IDLE : SCH_LOCK;
                end
            end
            SCH_LOCK: begin
                w_sel              = r_grant;
                req_ready[r_grant] = req_valid[r_grant];
                if (req_valid[r_grant]) begin
                    w_state_nxt = SCH_SEND;
                end
            end
            default: begin
                w_state_nxt = SCH_IDLE;
            end
        endcase
    end

    assign w_accept    = |(req_valid & req_ready);
    assign w_byte      = req_data[{w_sel, 3'b000} +: 8];
    assign w_grant_inc = (r_grant == ID_LAST) ? '0 : r_grant + 1'b1;

    // Capture owner and packet-end flag on acceptance; advance pointer after a packet ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr    <= '0;
            r_grant <= '0;
            r_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_sel;
                r_last  <= req_last[w_sel];
            end
            if (r_state == SCH_SEND && w_done && r_last) begin
                r_rr <= w_grant_inc;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .data  (w_byte),
        .tx    (tx),
        .done  (w_done)
    );

    assign busy     = (r_state != SCH_IDLE);
    assign grant_id = r_grant;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: one instance with four
// requesters at one clock per bit, one with three at three per bit.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  va = '0, la = '0, ra;
    logic [31:0] da = '0;
    logic        txa, busya;
    logic [1:0]  ga;

    logic [2:0]  vb = '0, lb = '0, rb;
    logic [23:0] db = '0;
    logic        txb, busyb;
    logic [1:0]  gb;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(4), .CLKS_PER_BIT(1)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (va),
        .req_data  (da),
        .req_last  (la),
        .req_ready (ra),
        .tx        (txa),
        .busy      (busya),
        .grant_id  (ga)
    );

    uart_tx_scheduler #(.N_REQ(3), .CLKS_PER_BIT(3)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (vb),
        .req_data  (db),
        .req_last  (lb),
        .req_ready (rb),
        .tx        (txb),
        .busy      (busyb),
        .grant_id  (gb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after the accepting posedge; samples every cycle of the frame.
    task automatic cap(input bit sel_b, input int c, input logic [7:0] d, input string tag);
        logic [9:0] o;
        logic       st;
        logic       s;
        o  = '0;
        st = 1'b1;
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < c; j++) begin
                @(negedge clk);
                s = sel_b ? txb : txa;
                if (j == 0) o[b] = s;
                else if (s !== o[b]) st = 1'b0;
            end
        end
        chk(tag, {22'd0, o}, {22'd0, 1'b1, d, 1'b0});
        if (c > 1) chk({tag, "_stable"}, {31'd0, st}, 32'd1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        va = '0; la = '0; vb = '0; lb = '0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_tx"}, {31'd0, txa}, 32'd1);
        chk({tag, "_ready"}, {28'd0, ra}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busya}, 32'd0);
        chk({tag, "_grant"}, {30'd0, ga}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] bytes2 [4];
        int         order2 [5];
        logic       ok;
        bytes2 = '{8'h10, 8'h21, 8'h32, 8'h43};
        order2 = '{0, 1, 2, 3, 0};

        do_reset("rst0");
        chk("rst0_txb", {31'd0, txb}, 32'd1);
        chk("rst0_readyb", {29'd0, rb}, 32'd0);

        // 1: single byte from requester 2
        @(negedge clk);
        va = 4'b0100; da[23:16] = 8'h48; la = 4'b0100;
        #1 chk("t1_ready", {28'd0, ra}, 32'h4);
        @(posedge clk);
        #1 va = '0;
        cap(1'b0, 1, 8'h48, "t1_frame");
        chk("t1_grant", {30'd0, ga}, 32'd2);
        chk("t1_busy_T10", {31'd0, busya}, 32'd1);
        @(negedge clk);
        chk("t1_busy_T11", {31'd0, busya}, 32'd0);

        // 2: four-way contention, one idle cycle between frames
        do_reset("rst2");
        @(negedge clk);
        va = 4'b1111; la = 4'b1111;
        da = {bytes2[3], bytes2[2], bytes2[1], bytes2[0]};
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_ready%0d", k), {28'd0, ra}, 32'd1 << order2[k]);
            chk($sformatf("t2_idle%0d", k), {31'd0, txa}, 32'd1);
            @(posedge clk);
            #1;
            if (k == 4) va = '0;
            cap(1'b0, 1, bytes2[order2[k]], $sformatf("t2_frame%0d", k));
            chk($sformatf("t2_grant%0d", k), {30'd0, ga}, order2[k]);
            @(negedge clk);
        end

        // 3: packet lock, req1 sends "Hi\n" while req0 waits
        va = 4'b0011; la = 4'b0001;
        da[7:0] = 8'h55; da[15:8] = 8'h48;
        #1 chk("t3_ready_H", {28'd0, ra}, 32'h2);
        @(posedge clk);
        #1 da[15:8] = 8'h69;
        cap(1'b0, 1, 8'h48, "t3_frame_H");
        chk("t3_send_ready", {28'd0, ra}, 32'h0);
        @(negedge clk);
        chk("t3_ready_i", {28'd0, ra}, 32'h2);
        @(posedge clk);
        #1 begin da[15:8] = 8'h0A; la = 4'b0011; end
        cap(1'b0, 1, 8'h69, "t3_frame_i");
        @(negedge clk);
        chk("t3_ready_nl", {28'd0, ra}, 32'h2);
        @(posedge clk);
        #1 va = 4'b0001;
        cap(1'b0, 1, 8'h0A, "t3_frame_nl");
        chk("t3_grant_nl", {30'd0, ga}, 32'd1);
        @(negedge clk);
        chk("t3_ready_req0", {28'd0, ra}, 32'h1);
        @(posedge clk);
        #1 va = '0;
        cap(1'b0, 1, 8'h55, "t3_frame_req0");
        chk("t3_grant_req0", {30'd0, ga}, 32'd0);

        // 4: owner stalls mid-packet for 50 cycles
        @(negedge clk);
        va = 4'b1001; la = 4'b0001;
        da[7:0] = 8'h55; da[31:24] = 8'hC3;
        #1 chk("t4_ready_req3", {28'd0, ra}, 32'h8);
        @(posedge clk);
        #1 va = 4'b0001;
        cap(1'b0, 1, 8'hC3, "t4_frame_C3");
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txa !== 1'b1 || ra !== 4'h0 || busya !== 1'b1) ok = 1'b0;
        end
        chk("t4_stall_quiet", {31'd0, ok}, 32'd1);
        va = 4'b1001; la = 4'b1001; da[31:24] = 8'h3C;
        #1 chk("t4_ready_resume", {28'd0, ra}, 32'h8);
        @(posedge clk);
        #1 va = 4'b0001;
        cap(1'b0, 1, 8'h3C, "t4_frame_3C");
        chk("t4_grant_3C", {30'd0, ga}, 32'd3);
        @(negedge clk);
        chk("t4_ready_req0", {28'd0, ra}, 32'h1);
        @(posedge clk);
        #1 va = '0;
        cap(1'b0, 1, 8'h55, "t4_frame_req0");

        // 5: reset during data bit 4
        @(negedge clk);
        va = 4'b0100; la = 4'b0100; da[23:16] = 8'h00;
        @(posedge clk);
        #1 va = '0;
        repeat (6) @(negedge clk);
        chk("t5_bit4_low", {31'd0, txa}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("t5_tx_async", {31'd0, txa}, 32'd1);
        chk("t5_busy_async", {31'd0, busya}, 32'd0);
        chk("t5_grant_async", {30'd0, ga}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        va = 4'b0011; la = 4'b0011;
        da[7:0] = 8'h96; da[15:8] = 8'h11;
        #1 chk("t5_rr_zero", {28'd0, ra}, 32'h1);
        @(posedge clk);
        #1 va = '0;
        cap(1'b0, 1, 8'h96, "t5_frame");
        chk("t5_grant", {30'd0, ga}, 32'd0);

        // 6: three clocks per bit, three requesters, pointer wrap 2->0
        @(negedge clk);
        vb = 3'b100; lb = 3'b100; db[23:16] = 8'hA5;
        #1 chk("t6_ready_req2", {29'd0, rb}, 32'h4);
        @(posedge clk);
        #1 begin
            vb = 3'b011; lb = 3'b011;
            db[7:0] = 8'h5A; db[15:8] = 8'h77;
        end
        cap(1'b1, 3, 8'hA5, "t6_frame_A5");
        chk("t6_grant_req2", {30'd0, gb}, 32'd2);
        chk("t6_ready_T30", {29'd0, rb}, 32'h0);
        @(negedge clk);
        chk("t6_ready_T31", {29'd0, rb}, 32'h1);
        chk("t6_idle_T31", {31'd0, txb}, 32'd1);
        @(posedge clk);
        #1 vb = '0;
        cap(1'b1, 3, 8'h5A, "t6_frame_5A");
        chk("t6_grant_req0", {30'd0, gb}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
